// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a UART transmitter over a start/done handshake.
// Absorbs bursty single-cycle writes and releases one byte per serial frame.
module uart_tx_fifo #(
    parameter int BITS_DATA = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_wr,
    input  logic [BITS_DATA-1:0] i_wr_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    output logic                 o_overflow,
    output logic                 o_tx_start,
    output logic [BITS_DATA-1:0] o_tx_data,
    input  logic                 i_tx_done,
    output logic                 o_busy
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0] FULL_COUNT = (ADDR_BITS + 1)'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;

    logic [BITS_DATA-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic [ADDR_BITS:0]   count;
    logic [1:0]           state;
    logic                 push;
    logic                 pop;

    assign o_full  = (count == FULL_COUNT);
    assign o_empty = (count == '0);
    assign o_count = count;
    assign o_busy  = (state == ST_WAIT);

    // Fullness is judged on the registered count, so a write racing a pop is still dropped.
    assign push = i_wr && !o_full;
    assign pop  = (state == ST_IDLE) && !o_empty;

    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_overflow <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_overflow <= i_wr && o_full;

            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                o_tx_data  <= mem[rd_ptr];
                o_tx_start <= 1'b1;
            end

            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (i_tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a vector table for single-byte handshakes,
// plus hand-written sequences with a simple transmitter model for the multi-cycle cases.
module tb_uart_tx_fifo;

    localparam int BITS_DATA = 8;
    localparam int ADDR_BITS = 4;

    logic                 i_clk = 1'b0;
    logic                 i_reset = 1'b0;
    logic                 i_wr = 1'b0;
    logic [BITS_DATA-1:0] i_wr_data = '0;
    logic                 i_tx_done = 1'b0;
    logic                 o_full;
    logic                 o_empty;
    logic [ADDR_BITS:0]   o_count;
    logic                 o_overflow;
    logic                 o_tx_start;
    logic [BITS_DATA-1:0] o_tx_data;
    logic                 o_busy;

    uart_tx_fifo #(.BITS_DATA(BITS_DATA), .ADDR_BITS(ADDR_BITS)) dut (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_wr       (i_wr),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .o_overflow (o_overflow),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       reset;
        logic       wr;
        logic [7:0] wr_data;
        logic       tx_done;
        logic       full;
        logic       empty;
        logic [4:0] count;
        logic       overflow;
        logic       tx_start;
        logic [7:0] tx_data;
        logic       busy;
    } vec_t;

    vec_t vecs [14];

    int checks = 0;
    int errors = 0;
    int edge_num = 0;
    int tx_timer = 0;
    bit auto_tx = 1'b0;
    logic [7:0] start_data [$];
    int start_edges [$];
    int done_edges [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        i_reset   = v.reset;
        i_wr      = v.wr;
        i_wr_data = v.wr_data;
        i_tx_done = v.tx_done;
        @(posedge i_clk);
        edge_num++;
        #1;
    endtask

    // One clock with the transmitter model: done pulses 50 edges after each observed start.
    task automatic stepCycle(input logic wr, input logic [7:0] data);
        i_wr      = wr;
        i_wr_data = data;
        i_tx_done = 1'b0;
        if (tx_timer > 0) begin
            tx_timer--;
            if (tx_timer == 0) begin
                i_tx_done = 1'b1;
                done_edges.push_back(edge_num + 1);
            end
        end
        @(posedge i_clk);
        edge_num++;
        #1;
        i_wr      = 1'b0;
        i_tx_done = 1'b0;
        if (o_tx_start) begin
            start_data.push_back(o_tx_data);
            start_edges.push_back(edge_num);
            if (auto_tx) tx_timer = 50;
        end
    endtask

    task automatic clearLog();
        start_data.delete();
        start_edges.delete();
        done_edges.delete();
        tx_timer = 0;
    endtask

    initial begin
        int first_edge;

        //                reset  wr    data    done   full  empty count  ovf   start data    busy
        vecs[0]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h00, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 8'hA5, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'hA5, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 8'h4D, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b1, 8'h3C, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 8'h3C, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 8'h4D, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h4D, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 8'h4D, 1'b0};

        // Reset followed by 20 idle cycles.
        i_reset = 1'b1;
        stepCycle(1'b0, 8'h00);
        i_reset = 1'b0;
        for (int c = 0; c < 20; c++) begin
            stepCycle(1'b0, 8'h00);
            checkOutput($sformatf("idle%0d.empty", c), 32'(o_empty), 32'd1);
            checkOutput($sformatf("idle%0d.count", c), 32'(o_count), 32'd0);
            checkOutput($sformatf("idle%0d.start", c), 32'(o_tx_start), 32'd0);
            checkOutput($sformatf("idle%0d.busy", c), 32'(o_busy), 32'd0);
        end

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d.full", i), 32'(o_full), 32'(vecs[i].full));
            checkOutput($sformatf("vec%0d.empty", i), 32'(o_empty), 32'(vecs[i].empty));
            checkOutput($sformatf("vec%0d.count", i), 32'(o_count), 32'(vecs[i].count));
            checkOutput($sformatf("vec%0d.overflow", i), 32'(o_overflow), 32'(vecs[i].overflow));
            checkOutput($sformatf("vec%0d.tx_start", i), 32'(o_tx_start), 32'(vecs[i].tx_start));
            checkOutput($sformatf("vec%0d.tx_data", i), 32'(o_tx_data), 32'(vecs[i].tx_data));
            checkOutput($sformatf("vec%0d.busy", i), 32'(o_busy), 32'(vecs[i].busy));
        end
        i_reset = 1'b0; i_wr = 1'b0; i_tx_done = 1'b0;

        // Burst of three; each start must be sampled one edge after the edge that sampled done.
        clearLog();
        auto_tx = 1'b1;
        first_edge = edge_num + 1;
        stepCycle(1'b1, 8'h11);
        stepCycle(1'b1, 8'h22);
        stepCycle(1'b1, 8'h33);
        for (int c = 0; c < 1000 && (start_data.size() < 3 || o_busy); c++) stepCycle(1'b0, 8'h00);
        checkOutput("burst.starts", 32'(start_data.size()), 32'd3);
        if (start_data.size() == 3 && done_edges.size() >= 2) begin
            checkOutput("burst.data0", 32'(start_data[0]), 32'h11);
            checkOutput("burst.data1", 32'(start_data[1]), 32'h22);
            checkOutput("burst.data2", 32'(start_data[2]), 32'h33);
            checkOutput("burst.lat0", 32'(start_edges[0]), 32'(first_edge + 1));
            checkOutput("burst.gap1", 32'(start_edges[1]), 32'(done_edges[0] + 1));
            checkOutput("burst.gap2", 32'(start_edges[2]), 32'(done_edges[1] + 1));
        end
        checkOutput("burst.count", 32'(o_count), 32'd0);
        checkOutput("burst.busy", 32'(o_busy), 32'd0);

        // Fill with done held low, overflow on write 18, then drain.
        clearLog();
        auto_tx = 1'b0;
        for (int k = 1; k <= 18; k++) begin
            stepCycle(1'b1, 8'(k - 1));
            if (k == 2) begin
                checkOutput("fill.first_start", 32'(o_tx_start), 32'd1);
                checkOutput("fill.first_data", 32'(o_tx_data), 32'h00);
            end
            if (k == 16) begin
                checkOutput("fill.full16", 32'(o_full), 32'd0);
                checkOutput("fill.count16", 32'(o_count), 32'd15);
            end
            if (k == 17) begin
                checkOutput("fill.full17", 32'(o_full), 32'd1);
                checkOutput("fill.count17", 32'(o_count), 32'd16);
                checkOutput("fill.ovf17", 32'(o_overflow), 32'd0);
            end
            if (k == 18) begin
                checkOutput("fill.ovf18", 32'(o_overflow), 32'd1);
                checkOutput("fill.count18", 32'(o_count), 32'd16);
            end
        end
        stepCycle(1'b0, 8'h00);
        checkOutput("fill.ovf_pulse", 32'(o_overflow), 32'd0);
        auto_tx = 1'b1;
        tx_timer = 5;
        for (int c = 0; c < 2000 && (start_data.size() < 17 || o_busy || !o_empty); c++) stepCycle(1'b0, 8'h00);
        checkOutput("fill.drained", 32'(start_data.size()), 32'd17);
        for (int i = 0; i < 17 && i < start_data.size(); i++)
            checkOutput($sformatf("fill.data%0d", i), 32'(start_data[i]), 32'(i));

        // Full FIFO, pop and write of 0xEE on the same edge.
        clearLog();
        auto_tx = 1'b0;
        for (int i = 0; i < 17; i++) stepCycle(1'b1, 8'(8'h40 + i));
        checkOutput("race.full", 32'(o_full), 32'd1);
        tx_timer = 1;
        stepCycle(1'b0, 8'h00);
        checkOutput("race.idle_busy", 32'(o_busy), 32'd0);
        checkOutput("race.idle_count", 32'(o_count), 32'd16);
        auto_tx = 1'b1;
        stepCycle(1'b1, 8'hEE);
        checkOutput("race.ovf", 32'(o_overflow), 32'd1);
        checkOutput("race.count", 32'(o_count), 32'd15);
        checkOutput("race.start", 32'(o_tx_start), 32'd1);
        checkOutput("race.data", 32'(o_tx_data), 32'h41);
        for (int c = 0; c < 2000 && (start_data.size() < 17 || o_busy || !o_empty); c++) stepCycle(1'b0, 8'h00);
        checkOutput("race.drained", 32'(start_data.size()), 32'd17);
        for (int i = 0; i < 17 && i < start_data.size(); i++)
            checkOutput($sformatf("race.data%0d", i), 32'(start_data[i]), 32'(8'h40 + i));

        // 40 bytes in chunks of ten so both pointers wrap several times.
        clearLog();
        auto_tx = 1'b1;
        for (int chunk = 0; chunk < 4; chunk++) begin
            for (int j = 0; j < 10; j++) stepCycle(1'b1, 8'(8'h80 + chunk * 10 + j));
            for (int c = 0; c < 1500 && (start_data.size() < (chunk + 1) * 10 || o_busy); c++) stepCycle(1'b0, 8'h00);
        end
        checkOutput("wrap.count_tx", 32'(start_data.size()), 32'd40);
        for (int i = 0; i < 40 && i < start_data.size(); i++)
            checkOutput($sformatf("wrap.data%0d", i), 32'(start_data[i]), 32'(8'h80 + i));

        // Reset while in WAIT with five bytes queued.
        clearLog();
        auto_tx = 1'b0;
        for (int i = 0; i < 6; i++) stepCycle(1'b1, 8'(8'hC0 + i));
        checkOutput("rst.pre_count", 32'(o_count), 32'd5);
        checkOutput("rst.pre_busy", 32'(o_busy), 32'd1);
        i_reset = 1'b1;
        stepCycle(1'b0, 8'h00);
        i_reset = 1'b0;
        checkOutput("rst.count", 32'(o_count), 32'd0);
        checkOutput("rst.busy", 32'(o_busy), 32'd0);
        checkOutput("rst.start", 32'(o_tx_start), 32'd0);
        checkOutput("rst.empty", 32'(o_empty), 32'd1);
        stepCycle(1'b0, 8'h00);
        checkOutput("rst.no_pop", 32'(o_tx_start), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Byte buffer and sequencer that sits directly upstream of the UART transmitter in the debug/communication path. It accepts bytes from the pipeline-side producer through a single-cycle write strobe and stores them in a circular FIFO. It then hands the bytes to the transmitter one at a time over the transmitter's start/done handshake. This decouples bursty writes (e.g. register/memory dumps) from the slow serial line.

## Interface
- `BITS_DATA`, 8, width of one byte/entry; must match the transmitter's data width
- `ADDR_BITS`, 4, log2 of FIFO depth (depth = 2^ADDR_BITS = 16)
- `i_clk`  in  1  system clock; all logic on rising edge
- `i_reset`  in  1  synchronous, active-high reset
- `i_wr`  in  1  write strobe; one byte accepted per cycle when not full
- `i_wr_data`  in  BITS_DATA  byte to enqueue, sampled when `i_wr`=1
- `o_full`  out  1  FIFO holds 2^ADDR_BITS entries
- `o_empty`  out  1  FIFO holds 0 entries
- `o_count`  out  ADDR_BITS+1  entries stored; excludes the byte currently on the line
- `o_overflow`  out  1  one-cycle pulse when a write is dropped because the FIFO is full
- `o_tx_start`  out  1  one-cycle pulse to transmitter; registered
- `o_tx_data`  out  BITS_DATA  byte for transmitter; valid with `o_tx_start`, held until the next pop
- `i_tx_done`  in  1  one-cycle completion pulse from transmitter (end of stop bit)
- `o_busy`  out  1  high while a byte is being transmitted (state WAIT)

## Operation
- Storage: register array of 2^ADDR_BITS entries. Write pointer `wr_ptr` and read pointer `rd_ptr` are ADDR_BITS wide and wrap modulo depth. Occupancy counter `count` is ADDR_BITS+1 wide.
- Write: if `i_wr`=1 and `count` < depth:
  - `mem[wr_ptr]` <= `i_wr_data`
  - `wr_ptr`+1
  - `count`+1
- Write when full: if `i_wr`=1 and `count` = depth, the byte is dropped, with no pointer or count change, and `o_overflow`=1 on the next cycle.
  - A write is dropped whenever `count` = depth at the write edge, even if a pop happens in the same cycle. Fullness is evaluated before the pop.
- Pop: happens in state IDLE when `count` != 0:
  - `o_tx_data` <= `mem[rd_ptr]`
  - `rd_ptr`+1
  - `count`-1
  - `o_tx_start` <= 1
- Simultaneous accepted write and pop: `count` unchanged; both pointers advance.
- Write to an empty FIFO: the byte is not popped in the same cycle. It becomes visible, and popped, on the following cycle.
- FSM, 2 states:
  - IDLE: if `count` != 0, pop and go to WAIT; else stay.
  - WAIT: `o_busy`=1. On `i_tx_done`=1, go to IDLE; else stay.
  - Illegal state encoding goes to IDLE.
- `i_tx_done` in IDLE is ignored.
- `o_tx_start` is high for exactly one cycle per popped byte. It is 0 in every other cycle.
- `o_full` = (`count` = depth); `o_empty` = (`count` = 0); both derived combinationally from the registered `count`.

## Timing
- Reset values:
  - state IDLE
  - `wr_ptr`=`rd_ptr`=0
  - `count`=0
  - `o_tx_start`=0
  - `o_tx_data`=0
  - `o_overflow`=0
  - `o_busy`=0
  - `o_empty`=1
  - `o_full`=0
  - `o_count`=0
  - Memory contents need not be cleared.
- Reset mid-transmission: the FIFO and FSM clear immediately and queued bytes are lost. The transmitter is reset by the same `i_reset`.
- Write-to-start latency, empty FIFO, IDLE:
  - write at edge N
  - pop at edge N+1
  - `o_tx_start`=1 during cycle N+1..N+2, with `o_tx_data` valid
- Back-to-back: `i_tx_done` sampled at edge M puts the FSM in IDLE. The pop happens at edge M+1, so `o_tx_start` rises 2 cycles after the done pulse. The transmitter has returned to idle by then and is driving the line high.
- `o_count` and `o_full` change one cycle after the accepted write or pop edge.
- Throughput: one byte per transmitter frame plus 2 clock cycles.

## Test plan
- Reset, then no writes for 20 cycles -> `o_empty`=1, `o_count`=0, `o_tx_start` never asserted, `o_busy`=0.
- Single write 0xA5 into an empty FIFO -> `o_tx_start` pulses once, 2 cycles after the write, with `o_tx_data`=0xA5. `o_busy`=1 until the `i_tx_done` pulse, and `o_count` returns to 0.
- Burst of 3 writes 0x11, 0x22, 0x33 on consecutive cycles, with transmitter model pulsing `i_tx_done` 50 cycles after each start -> 3 starts, in order 0x11, 0x22, 0x33. Each start comes exactly 2 cycles after the previous done.
- With `i_tx_done` held low, write 18 bytes 0x00..0x11:
  - first byte popped at once
  - `o_full`=1 after 17 accepted writes (`o_count`=16)
  - write 18 dropped, `o_overflow` pulses once
  - draining yields 0x00..0x10 in order
- With FIFO full and the FSM popping on the same edge as a write of 0xEE -> 0xEE is dropped, `o_overflow`=1, `o_count`=15.
- Wrap-around: push and drain 40 bytes with an incrementing pattern -> every byte is transmitted in order with no loss. Assert `i_reset` while in WAIT with 5 bytes queued -> next cycle `o_count`=0, `o_busy`=0, `o_tx_start`=0.
